// File: rtl/card_shuffler.sv
// Builds a shuffled memory-card layout: N_CARDS/2 colour pairs, Fisher-Yates shuffled with a Galois LFSR.
// Optional macro SHUFFLE_FIXED_SEED_EN: LFSR advances only while shuffling, so the layout after reset is deterministic.
module card_shuffler #(
    parameter int          N_CARDS   = 16,
    parameter int          IDX_W     = 4,
    parameter int          COLOR_W   = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         compute_colors_en,
    output logic                         compute_done,
    output logic [N_CARDS*COLOR_W-1:0]   cards_colors,
    output logic                         shuffle_busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_INIT    = 2'd1;
    localparam logic [1:0] ST_SHUFFLE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0]      SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CARDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] fb;
        fb = v[0] ? LFSR_TAPS : 16'h0000;
        return (v >> 1) ^ fb;
    endfunction

    // Smear every bit below the MSB to get the smallest 2^k-1 covering v.
    function automatic logic [IDX_W-1:0] span_mask(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = v;
        for (int b = 1; b < IDX_W; b++) begin
            m = m | (v >> b);
        end
        return m;
    endfunction

    logic [1:0]                 state_r;
    logic [IDX_W-1:0]           idx_r;
    logic [N_CARDS*COLOR_W-1:0] cards_r;
    logic [15:0]                lfsr_r;
    logic                       done_r;
    logic                       busy_r;

    logic [IDX_W-1:0]           cand_s;
    logic                       accept_s;
    logic [COLOR_W-1:0]         card_i_s;
    logic [COLOR_W-1:0]         card_j_s;
    logic                       lfsr_step_s;

    // Candidate partner for the current card and the two colours to swap.
    always_comb begin
        cand_s   = lfsr_r[IDX_W-1:0] & span_mask(idx_r);
        accept_s = (cand_s <= idx_r);
        card_i_s = cards_r[idx_r*COLOR_W +: COLOR_W];
        card_j_s = cards_r[cand_s*COLOR_W +: COLOR_W];
    end

    // LFSR advance enable: free-running by default, shuffle-only for reproducible layouts.
    always_comb begin
`ifdef SHUFFLE_FIXED_SEED_EN
        if (state_r == ST_SHUFFLE) begin
            lfsr_step_s = 1'b1;
        end else begin
            lfsr_step_s = 1'b0;
        end
`else
        lfsr_step_s = 1'b1;
`endif
    end

    // Request FSM, card storage and LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cards_r <= '0;
            lfsr_r  <= SEED_EFF;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (lfsr_step_s) begin
                lfsr_r <= lfsr_next(lfsr_r);
            end
            case (state_r)
                ST_IDLE: begin
                    if (compute_colors_en) begin
                        state_r <= ST_INIT;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (!compute_colors_en) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cards_r[idx_r*COLOR_W +: COLOR_W] <= COLOR_W'(idx_r >> 1);
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_SHUFFLE;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                ST_SHUFFLE: begin
                    if (!compute_colors_en) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (accept_s) begin
                        // When cand_s == idx_r both writes carry the same colour.
                        cards_r[idx_r*COLOR_W +: COLOR_W]  <= card_j_s;
                        cards_r[cand_s*COLOR_W +: COLOR_W] <= card_i_s;
                        if (idx_r == IDX_ONE) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            idx_r <= idx_r - IDX_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!compute_colors_en) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign compute_done = done_r;
    assign cards_colors = cards_r;
    assign shuffle_busy = busy_r;

endmodule

// File: tb/tb_card_shuffler.sv
// Directed bench for card_shuffler (default build, free-running LFSR): reset, full runs with an
// independent Fisher-Yates reference, hold/release, aborts, start-time dependence and mid-run reset.
module tb_card_shuffler;

    logic        clk;
    logic        rst;
    logic        compute_colors_en;
    logic        compute_done;
    logic [47:0] cards_colors;
    logic        shuffle_busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_lfsr;
    logic [47:0] lay_a;
    logic [47:0] lay_b;
    logic [47:0] lay_c;

    card_shuffler dut (
        .clk               (clk),
        .rst               (rst),
        .compute_colors_en (compute_colors_en),
        .compute_done      (compute_done),
        .cards_colors      (cards_colors),
        .shuffle_busy      (shuffle_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] model_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ ({16{l[0]}} & 16'hB400);
    endfunction

    // Reference LFSR: reloads on reset, otherwise advances every edge.
    always @(posedge clk) begin
        if (rst) ref_lfsr <= 16'hACE1;
        else     ref_lfsr <= model_step(ref_lfsr);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void predict(input logic [15:0] l0, output logic [47:0] lay, output int n);
        int deck[16];
        int i;
        int j;
        int m;
        int t;
        logic [15:0] l;
        for (int k = 0; k < 16; k++) deck[k] = k / 2;
        i = 15;
        n = 0;
        l = l0;
        while (i > 0 && n < 1000) begin
            m = 1;
            while (m < i) m = m * 2 + 1;
            j = int'(l[3:0]) & m;
            if (j <= i) begin
                t = deck[i];
                deck[i] = deck[j];
                deck[j] = t;
                i--;
            end
            l = model_step(l);
            n++;
        end
        lay = '0;
        for (int k = 0; k < 16; k++) lay[k*3 +: 3] = 3'(deck[k]);
    endfunction

    task automatic check_pairs();
        int cnt;
        for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int k = 0; k < 16; k++) begin
                if (cards_colors[k*3 +: 3] == 3'(c)) cnt++;
            end
            check_eq("pair_count", 64'(cnt), 64'd2);
        end
    endtask

    // Raises en from IDLE and follows one complete run to compute_done.
    task automatic run_full(output logic [47:0] lay);
        logic [15:0] l0;
        int n;
        compute_colors_en = 1'b1;
        tick();
        check_eq("busy_on", 64'(shuffle_busy), 64'd1);
        repeat (16) tick();
        l0 = ref_lfsr;
        predict(l0, lay, n);
        check_eq("latency_bound", 64'(n <= 400), 64'd1);
        if (n > 400) n = 400;
        for (int k = 1; k < n; k++) tick();
        check_eq("done_early", 64'(compute_done), 64'd0);
        tick();
        check_eq("done_rise", 64'(compute_done), 64'd1);
        check_eq("busy_off_done", 64'(shuffle_busy), 64'd0);
        check_eq("layout", 64'(cards_colors), 64'(lay));
        check_pairs();
    endtask

    initial begin
        rst = 1'b1;
        compute_colors_en = 1'b0;
        tick();
        tick();
        check_eq("rst_done", 64'(compute_done), 64'd0);
        check_eq("rst_busy", 64'(shuffle_busy), 64'd0);
        check_eq("rst_cards", 64'(cards_colors), 64'd0);

        rst = 1'b0;
        repeat (3) tick();
        run_full(lay_a);

        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("hold_done", 64'(compute_done), 64'd1);
            check_eq("hold_layout", 64'(cards_colors), 64'(lay_a));
        end
        compute_colors_en = 1'b0;
        tick();
        check_eq("release_done", 64'(compute_done), 64'd0);
        check_eq("release_layout", 64'(cards_colors), 64'(lay_a));
        check_eq("release_busy", 64'(shuffle_busy), 64'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (40) tick();
        run_full(lay_b);
        check_eq("start_time_matters", 64'(cards_colors != lay_a), 64'd1);
        compute_colors_en = 1'b0;
        tick();

        // Abort while INIT is working on card 5: cards 0..4 hold 0,0,1,1,2.
        compute_colors_en = 1'b1;
        repeat (6) tick();
        compute_colors_en = 1'b0;
        tick();
        check_eq("abort_init_busy", 64'(shuffle_busy), 64'd0);
        check_eq("abort_init_done", 64'(compute_done), 64'd0);
        check_eq("abort_init_cards", 64'(cards_colors[14:0]), 64'h2240);
        repeat (3) tick();
        check_eq("abort_init_idle", 64'(compute_done), 64'd0);

        compute_colors_en = 1'b1;
        repeat (21) tick();
        compute_colors_en = 1'b0;
        tick();
        check_eq("abort_shuf_busy", 64'(shuffle_busy), 64'd0);
        check_eq("abort_shuf_done", 64'(compute_done), 64'd0);
        tick();
        check_eq("abort_shuf_idle", 64'(compute_done), 64'd0);
        run_full(lay_c);
        compute_colors_en = 1'b0;
        tick();

        compute_colors_en = 1'b1;
        repeat (25) tick();
        rst = 1'b1;
        compute_colors_en = 1'b0;
        tick();
        check_eq("midrst_done", 64'(compute_done), 64'd0);
        check_eq("midrst_busy", 64'(shuffle_busy), 64'd0);
        check_eq("midrst_cards", 64'(cards_colors), 64'd0);
        rst = 1'b0;
        repeat (7) tick();
        run_full(lay_c);
        compute_colors_en = 1'b0;
        tick();
        check_eq("final_release", 64'(compute_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
